code_lock_ctrl: RTL and testbench
=================================

Name: code_lock_ctrl

Overview:
Sequencing controller around the board's 4-bit switch-digit comparator. The user enters a multi-digit code one digit at a time: a digit is set on the switches and an enter strobe is pulsed (derived from a KEY). The block tracks the digit position, accumulates the match result and holds an unlock indication for a fixed time. It also counts failed attempts and enforces a timed lockout. It sits between the debounced KEY/SW inputs and the LEDR indicators.

Parameters:
- NUM_DIGITS, 2, number of digits per code (1..8).
- CODE, 8'h28, expected code packed 4 bits per digit. CODE[3:0] is the first digit entered, CODE[7:4] the second, and so on. Width is 4*NUM_DIGITS.
- MAX_TRIES, 3, consecutive failed attempts that trigger lockout (>=1).
- UNLOCK_CYCLES, 500, clock cycles that unlocked is held (>=1).
- LOCKOUT_CYCLES, 1000, clock cycles that locked_out is held (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enter  input  1  single-cycle, synchronous, already-debounced strobe; samples digit.
- digit  input  4  digit value from SW[3:0].
- unlocked  output  1  high while in UNLOCKED.
- locked_out  output  1  high while in LOCKOUT.
- error  output  1  one-cycle pulse on each failed attempt.
- digit_idx  output  $clog2(NUM_DIGITS+1)  number of digits accepted in the current attempt.
- fail_count  output  $clog2(MAX_TRIES+1)  consecutive failed attempts.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; all outputs 0; internal mismatch flag and timer cleared. Reset mid-attempt, mid-unlock or mid-lockout discards everything and returns to IDLE.
- States: IDLE, ENTRY, UNLOCKED, LOCKOUT. All outputs are registered; changes become visible after the sampling edge.
- IDLE/ENTRY, enter=1 (digit accept):
  - Compare digit with CODE[4*digit_idx +: 4]; OR any mismatch into a sticky flag.
  - Increment digit_idx.
  - IDLE moves to ENTRY on the first accepted digit.
- Final digit (accepted digit is number NUM_DIGITS), evaluated on the same edge, including that digit's comparison:
  - All matched: go to UNLOCKED; fail_count <= 0.
  - Any mismatch, fail_count+1 < MAX_TRIES: go to IDLE; fail_count++; error pulses for 1 cycle.
  - Any mismatch, fail_count+1 == MAX_TRIES: go to LOCKOUT; fail_count <= MAX_TRIES; error pulses for 1 cycle.
  - In every case digit_idx <= 0 and the mismatch flag is cleared.
  - With NUM_DIGITS=1, IDLE goes directly to the outcome state.
- enter=0: state and counters hold. An attempt never times out.
- UNLOCKED: timer counts up from 0. unlocked is high for exactly UNLOCK_CYCLES cycles, then state returns to IDLE. enter is ignored.
- LOCKOUT: locked_out is high for exactly LOCKOUT_CYCLES cycles. On exit to IDLE, fail_count <= 0. enter is ignored.
- Non-BCD digits (10..15) are compared as raw 4-bit values. Since CODE is BCD, they count as mismatches.
- Timer width: $clog2 of max(UNLOCK_CYCLES, LOCKOUT_CYCLES). The timer is cleared on every state entry.
- fail_count does not wrap; it saturates at MAX_TRIES.

Optional Feature:
CODE_LOCK_CLEAR_EN
- Defined: adds input port clear (1 bit, synchronous strobe).
  - clear=1 in IDLE/ENTRY aborts the attempt: digit_idx <= 0, mismatch flag cleared, state IDLE, fail_count unchanged, no error pulse.
  - If clear and enter occur in the same cycle, clear wins and the digit is discarded.
  - clear is ignored in UNLOCKED/LOCKOUT.
- Not defined: the clear port is absent and attempts can only end by entering NUM_DIGITS digits or by reset.

Test Plan (NUM_DIGITS=2, CODE=8'h28, MAX_TRIES=2, UNLOCK_CYCLES=4, LOCKOUT_CYCLES=8):
- Correct code: reset, then enter digit=8, then enter digit=2 -> digit_idx goes 0,1,0; unlocked high for exactly 4 cycles after the second edge, then 0; error never pulses; fail_count stays 0.
- First-digit mismatch: enter 3, then enter 2 -> no unlock; error high for 1 cycle; fail_count=1; state IDLE, digit_idx=0.
- Lockout: two wrong attempts (1,1 then 9,9) -> second attempt gives an error pulse and locked_out high for 8 cycles. Enter 8,2 during lockout -> ignored, digit_idx stays 0. After lockout, fail_count=0; then entering 8,2 unlocks.
- Success resets failures: one wrong attempt (fail_count=1), then 8,2 -> unlocked asserted, fail_count=0.
- Async reset mid-entry: enter 8, assert reset_n low between edges -> all outputs 0 immediately. After release, enter 2 then 8 -> mismatch (2 is treated as the first digit), error pulse.
- With CODE_LOCK_CLEAR_EN: enter 8, then clear, then enter 8, then enter 2 -> unlocked, no error. Also clear and enter in the same cycle -> digit_idx=0.

Source files
------------

// File: rtl/code_lock_ctrl.sv
// Multi-digit code lock sequencer: digit entry, timed unlock, failed-attempt lockout.
// Optional `CODE_LOCK_CLEAR_EN adds a synchronous clear strobe that aborts an attempt.
module code_lock_ctrl #(
  parameter int unsigned                NUM_DIGITS     = 2,
  parameter logic [4*NUM_DIGITS-1:0]    CODE           = 8'h28,
  parameter int unsigned                MAX_TRIES      = 3,
  parameter int unsigned                UNLOCK_CYCLES  = 500,
  parameter int unsigned                LOCKOUT_CYCLES = 1000
) (
  input  logic                                clk,
  input  logic                                reset_n,
`ifdef CODE_LOCK_CLEAR_EN
  input  logic                                clear,
`endif
  input  logic                                enter,
  input  logic [3:0]                          digit,
  output logic                                unlocked,
  output logic                                locked_out,
  output logic                                error,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     digit_idx,
  output logic [$clog2(MAX_TRIES+1)-1:0]      fail_count
);

  localparam int unsigned DW   = $clog2(NUM_DIGITS + 1);
  localparam int unsigned FW   = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DW-1:0] LAST_IDX = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] MAX_F    = FW'(MAX_TRIES);
  localparam logic [TW-1:0] U_LAST   = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] L_LAST   = TW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_UNLOCKED,
    S_LOCKOUT
  } state_t;

  state_t        state;
  logic          mismatch;
  logic [TW-1:0] timer;

  logic [3:0]    exp_digit;
  logic          any_mm;
  logic [FW-1:0] fail_inc;
  logic          abort;

`ifdef CODE_LOCK_CLEAR_EN
  assign abort = clear;
`else
  assign abort = 1'b0;
`endif

  // Expected digit for the current position, selected with constant slices only.
  always_comb begin
    exp_digit = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == DW'(i)) exp_digit = CODE[4*i +: 4];
    end
    any_mm   = mismatch | (digit != exp_digit);
    fail_inc = fail_count + FW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      mismatch   <= 1'b0;
      timer      <= '0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      error      <= 1'b0;
      digit_idx  <= '0;
      fail_count <= '0;
    end else begin
      error <= 1'b0;
      case (state)
        S_IDLE, S_ENTRY: begin
          if (abort) begin
            state     <= S_IDLE;
            digit_idx <= '0;
            mismatch  <= 1'b0;
          end else if (enter) begin
            if (digit_idx == LAST_IDX) begin
              // Final digit: outcome includes this digit's own comparison.
              digit_idx <= '0;
              mismatch  <= 1'b0;
              timer     <= '0;
              if (!any_mm) begin
                state      <= S_UNLOCKED;
                unlocked   <= 1'b1;
                fail_count <= '0;
              end else if (fail_inc == MAX_F) begin
                state      <= S_LOCKOUT;
                locked_out <= 1'b1;
                fail_count <= MAX_F;
                error      <= 1'b1;
              end else begin
                state      <= S_IDLE;
                fail_count <= fail_inc;
                error      <= 1'b1;
              end
            end else begin
              state     <= S_ENTRY;
              digit_idx <= digit_idx + DW'(1);
              mismatch  <= any_mm;
            end
          end
        end
        S_UNLOCKED: begin
          if (timer == U_LAST) begin
            state    <= S_IDLE;
            unlocked <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_LOCKOUT: begin
          if (timer == L_LAST) begin
            state      <= S_IDLE;
            locked_out <= 1'b0;
            fail_count <= '0;
            timer      <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Self-checking bench for code_lock_ctrl: directed scenarios plus randomized entry
// against an attempt-level reference model (digit queue, remaining-cycle counters).
module tb_code_lock_ctrl;

  localparam int NUM = 2;
  localparam int CODE_V = 'h28;
  localparam int MAXT = 2;
  localparam int UC = 4;
  localparam int LC = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enter = 1'b0;
  logic [3:0] digit = '0;
  logic       unlocked, locked_out, error;
  logic [1:0] digit_idx;
  logic [1:0] fail_count;
`ifdef CODE_LOCK_CLEAR_EN
  logic       clear = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  code_lock_ctrl #(
    .NUM_DIGITS(NUM), .CODE(8'h28), .MAX_TRIES(MAXT),
    .UNLOCK_CYCLES(UC), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .reset_n(reset_n),
`ifdef CODE_LOCK_CLEAR_EN
    .clear(clear),
`endif
    .enter(enter), .digit(digit),
    .unlocked(unlocked), .locked_out(locked_out), .error(error),
    .digit_idx(digit_idx), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  // Reference model: digits of the current attempt, failure count, remaining hold cycles.
  int m_q[$];
  int m_fails, m_unlock, m_lock;
  bit m_err;

  function automatic void model_reset();
    m_q.delete();
    m_fails = 0; m_unlock = 0; m_lock = 0; m_err = 0;
  endfunction

  function automatic void model_step(bit en, int d, bit clr);
    bit ok;
    m_err = 0;
    if (m_unlock > 0) m_unlock--;
    else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (clr) m_q.delete();
    else if (en) begin
      m_q.push_back(d);
      if (m_q.size() == NUM) begin
        ok = 1;
        for (int i = 0; i < NUM; i++)
          if (m_q[i] != ((CODE_V >> (4*i)) % 16)) ok = 0;
        m_q.delete();
        if (ok) begin
          m_unlock = UC;
          m_fails = 0;
        end else begin
          m_fails++;
          m_err = 1;
          if (m_fails == MAXT) m_lock = LC;
        end
      end
    end
  endfunction

  function automatic logic [6:0] model_vec();
    return {m_unlock > 0, m_lock > 0, m_err, 2'(m_q.size()), 2'(m_fails)};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {unlocked, locked_out, error, digit_idx, fail_count};
  endfunction

  task automatic step(input bit en, input int d, input bit clr);
    enter = en;
    digit = 4'(d);
`ifdef CODE_LOCK_CLEAR_EN
    clear = clr;
`endif
    @(posedge clk);
`ifdef CODE_LOCK_CLEAR_EN
    model_step(en, d, clr);
`else
    model_step(en, d, 1'b0);
`endif
    #1;
    enter = 1'b0;
`ifdef CODE_LOCK_CLEAR_EN
    clear = 1'b0;
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== 7'b0) begin
      errors++;
      $display("FAIL reset: got %b want %b", dut_vec(), 7'b0);
    end
  endtask

  // Each row: enter, digit. Idle rows let the unlock window run out.
  task automatic test_correct_code();
    int en_t[8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    int d_t[8]  = '{8, 2, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      step(en_t[i][0], d_t[i], 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL correct_code[%0d]: got %b want %b", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if (unlocked !== 1'b0 || fail_count !== 2'd0) begin
      errors++;
      $display("FAIL correct_code_end: got unl=%b fc=%0d want unl=0 fc=0", unlocked, fail_count);
    end
  endtask

  task automatic test_first_digit_mismatch();
    int d_t[3] = '{3, 2, 0};
    for (int i = 0; i < 3; i++) begin
      step(i < 2, d_t[i], 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL first_mismatch[%0d]: got %b want %b", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_lockout();
    int en_t[$];
    int d_t[$];
    en_t = '{1, 1, 1, 1, 1, 1};
    d_t  = '{1, 1, 9, 9, 8, 2};
    for (int i = 0; i < 8; i++) begin en_t.push_back(0); d_t.push_back(0); end
    en_t.push_back(1); d_t.push_back(8);
    en_t.push_back(1); d_t.push_back(2);
    for (int i = 0; i < 6; i++) begin en_t.push_back(0); d_t.push_back(0); end
    for (int i = 0; i < en_t.size(); i++) begin
      step(en_t[i][0], d_t[i], 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL lockout[%0d]: got %b want %b", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_success_resets_failures();
    int d_t[6] = '{5, 5, 8, 2, 0, 0};
    for (int i = 0; i < 6; i++) begin
      step(i < 4, d_t[i], 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL success_resets[%0d]: got %b want %b", i, dut_vec(), model_vec());
      end
    end
    repeat (4) step(1'b0, 0, 1'b0);
  endtask

  task automatic test_async_reset();
    step(1'b1, 8, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: got %b want %b", dut_vec(), 7'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 2, 1'b0);
    step(1'b1, 8, 1'b0);
    checks++;
    if (dut_vec() !== model_vec() || error !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_after: got %b want %b", dut_vec(), model_vec());
    end
  endtask

`ifdef CODE_LOCK_CLEAR_EN
  task automatic test_clear();
    int en_t[6]  = '{1, 0, 1, 1, 1, 0};
    int d_t[6]   = '{8, 0, 8, 2, 8, 0};
    int clr_t[6] = '{0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      step(en_t[i][0], d_t[i], clr_t[i][0]);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL clear[%0d]: got %b want %b", i, dut_vec(), model_vec());
      end
    end
    repeat (4) step(1'b0, 0, 1'b0);
    step(1'b1, 8, 1'b1);
    checks++;
    if (digit_idx !== 2'd0 || dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL clear_with_enter: got %b want %b", dut_vec(), model_vec());
    end
  endtask
`endif

  task automatic test_random();
    bit en, clr;
    int d;
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 15);
      else d = (m_q.size() == 0) ? 8 : 2;
      clr = 1'b0;
`ifdef CODE_LOCK_CLEAR_EN
      clr = ($urandom_range(0, 15) == 0);
`endif
      step(en, d, clr);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %b want %b", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_correct_code();
    test_first_digit_mismatch();
    do_reset();
    test_lockout();
    test_success_resets_failures();
    test_async_reset();
`ifdef CODE_LOCK_CLEAR_EN
    do_reset();
    test_clear();
`endif
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
